// File: rtl/prbs_pkg.sv
// Shared constants and state encoding for the PRBS31 burst scheduler.
package prbs_pkg;

    localparam int unsigned          LFSR_W     = 31;
    localparam int unsigned          TAP_HI     = 30;
    localparam int unsigned          TAP_LO     = 27;
    localparam logic [LFSR_W-1:0]    RESET_SEED = 31'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

endpackage

// File: rtl/prbs31_core.sv
// PRBS31 (x^31 + x^28 + 1) shift register with seed load and single-step control.
module prbs31_core
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q,
    output logic              msb
);

    logic [LFSR_W-1:0] r_lfsr;

    // Seed load has priority; an all-zero seed would lock the LFSR, so substitute the reset seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= RESET_SEED;
        end else if (load) begin
            r_lfsr <= (load_val == '0) ? RESET_SEED : load_val;
        end else if (step) begin
            r_lfsr <= {r_lfsr[TAP_HI-1:0], r_lfsr[TAP_HI] ^ r_lfsr[TAP_LO]};
        end
    end

    assign q   = r_lfsr;
    assign msb = r_lfsr[TAP_HI];

endmodule

// File: rtl/prbs_burst_sched.sv
// Round-robin burst scheduler sharing one PRBS31 generator between NREQ requesters.
module prbs_burst_sched
    import prbs_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   len,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    output logic [NREQ-1:0]         grant,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic [$clog2(NREQ)-1:0] bit_id,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    seed_err
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned CNT_W = LEN_W + 1;

    state_t            r_state, w_nxt_state;
    logic [NREQ-1:0]   r_grant, w_nxt_grant;
    logic              r_bit_out, w_nxt_bit_out;
    logic              r_bit_valid, w_nxt_bit_valid;
    logic [ID_W-1:0]   r_bit_id, w_nxt_bit_id;
    logic [NREQ-1:0]   r_done, w_nxt_done;
    logic              r_busy, w_nxt_busy;
    logic              r_seed_err, w_nxt_seed_err;
    logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [ID_W-1:0]   r_rr, w_nxt_rr;
    logic [ID_W-1:0]   r_owner, w_nxt_owner;

    logic              w_step, w_load, w_msb, w_any;
    logic [ID_W-1:0]   w_win, w_idx;
    logic [LEN_W-1:0]  w_len;
    logic [LFSR_W-1:0] w_lfsr_q;
    logic              w_unused_q;
    int unsigned       w_sum;

    prbs31_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (w_step),
        .load     (w_load),
        .load_val (seed),
        .q        (w_lfsr_q),
        .msb      (w_msb)
    );

    // Full register value is only observed for debug; the stream taps the MSB.
    assign w_unused_q = ^w_lfsr_q;

    // Round-robin pick: first set request at or above the pointer, wrapping.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        w_sum = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = 32'(r_rr) + k;
            if (w_sum >= NREQ) w_sum = w_sum - NREQ;
            w_idx = ID_W'(w_sum);
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_len = len[32'(w_win)*LEN_W +: LEN_W];

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_grant     = r_grant;
        w_nxt_bit_out   = r_bit_out;
        w_nxt_bit_valid = r_bit_valid;
        w_nxt_bit_id    = r_bit_id;
        w_nxt_done      = r_done;
        w_nxt_busy      = r_busy;
        w_nxt_seed_err  = r_seed_err;
        w_nxt_cnt       = r_cnt;
        w_nxt_rr        = r_rr;
        w_nxt_owner     = r_owner;
        w_step          = 1'b0;
        w_load          = 1'b0;
        case (r_state)
            IDLE: begin
                if (seed_load) begin
                    w_load = 1'b1;
                end else if (w_any) begin
                    w_nxt_state = RUN;
                    w_nxt_grant = NREQ'(1) << w_win;
                    w_nxt_busy  = 1'b1;
                    w_nxt_owner = w_win;
                    w_nxt_cnt   = (w_len == '0) ? {1'b1, {LEN_W{1'b0}}} : CNT_W'(w_len);
                    w_nxt_rr    = (32'(w_win) + 1 >= NREQ) ? '0 : ID_W'(32'(w_win) + 1);
                end
            end
            RUN: begin
                w_step          = 1'b1;
                w_nxt_bit_out   = w_msb;
                w_nxt_bit_valid = 1'b1;
                w_nxt_bit_id    = r_owner;
                w_nxt_cnt       = r_cnt - CNT_W'(1);
                w_nxt_done      = '0;
                if (r_cnt == CNT_W'(1)) begin
                    w_nxt_done  = NREQ'(1) << r_owner;
                    w_nxt_state = TAIL;
                end
                if (seed_load) w_nxt_seed_err = 1'b1;
            end
            TAIL: begin
                w_nxt_bit_valid = 1'b0;
                w_nxt_done      = '0;
                w_nxt_grant     = '0;
                w_nxt_busy      = 1'b0;
                w_nxt_state     = IDLE;
                if (seed_load) w_nxt_seed_err = 1'b1;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_id    <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_seed_err  <= 1'b0;
            r_cnt       <= '0;
            r_rr        <= '0;
            r_owner     <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_grant     <= w_nxt_grant;
            r_bit_out   <= w_nxt_bit_out;
            r_bit_valid <= w_nxt_bit_valid;
            r_bit_id    <= w_nxt_bit_id;
            r_done      <= w_nxt_done;
            r_busy      <= w_nxt_busy;
            r_seed_err  <= w_nxt_seed_err;
            r_cnt       <= w_nxt_cnt;
            r_rr        <= w_nxt_rr;
            r_owner     <= w_nxt_owner;
        end
    end

    assign grant     = r_grant;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_id    = r_bit_id;
    assign done      = r_done;
    assign busy      = r_busy;
    assign seed_err  = r_seed_err;

endmodule

// File: tb/tb_prbs_burst_sched.sv
// Self-checking bench for prbs_burst_sched against a sequence-level PRBS31 and round-robin model.
module tb_prbs_burst_sched;

    localparam int NREQ  = 4;
    localparam int LEN_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] len = '0;
    logic                  seed_load = 1'b0;
    logic [30:0]           seed = '0;
    logic [NREQ-1:0]       grant;
    logic                  bit_out;
    logic                  bit_valid;
    logic [1:0]            bit_id;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  seed_err;

    int checks = 0;
    int errors = 0;

    prbs_burst_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .seed_load(seed_load), .seed(seed),
        .grant(grant), .bit_out(bit_out), .bit_valid(bit_valid), .bit_id(bit_id),
        .done(done), .busy(busy), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    // Reference model: the PRBS is a bit sequence x[n+31] = x[n] ^ x[n+3]; m_win holds the next 31 bits.
    bit m_win[$];
    int m_rr;
    bit obs_bits[$];
    int obs_ids[$];

    function automatic void m_seed(input logic [30:0] s);
        logic [30:0] v;
        v = (s == 31'd0) ? 31'd1 : s;
        m_win.delete();
        for (int i = 0; i < 31; i++) m_win.push_back(v[30-i]);
    endfunction

    function automatic bit m_next();
        bit b;
        bit f;
        b = m_win[0];
        f = m_win[0] ^ m_win[3];
        void'(m_win.pop_front());
        m_win.push_back(f);
        return b;
    endfunction

    function automatic int m_pick(input logic [NREQ-1:0] r);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (r[idx]) begin
                m_rr = (idx + 1) % NREQ;
                return idx;
            end
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        seed_load = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        m_seed(31'd1);
        m_rr = 0;
    endtask

    // Observe a granted burst from cycle T+2 until grant/busy drop; cycle index c is relative to T.
    task automatic watch_burst(input int budget, input int seed_at, input logic [30:0] seed_v,
                               output int nb, output int nd, output int first_v, output int done_at,
                               output int drop_at, output logic [NREQ-1:0] done_vec);
        nb = 0; nd = 0; first_v = -1; done_at = -1; drop_at = -1; done_vec = '0;
        obs_bits.delete();
        obs_ids.delete();
        for (int c = 2; c <= budget; c++) begin
            if (c == seed_at) begin
                seed_load = 1'b1;
                seed = seed_v;
            end
            tick();
            seed_load = 1'b0;
            if (bit_valid) begin
                nb++;
                obs_bits.push_back(bit_out);
                obs_ids.push_back(int'(bit_id));
                if (first_v < 0) first_v = c;
            end
            if (done != '0) begin
                nd++;
                done_at = c;
                done_vec = done;
            end
            if (!busy && grant == '0) begin
                drop_at = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if ({bit_out, bit_valid} !== 2'b00) begin errors++; $display("FAIL reset_bit: got %b want 00", {bit_out, bit_valid}); end
        checks++; if (bit_id !== 2'd0) begin errors++; $display("FAIL reset_bit_id: got %0d want 0", bit_id); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if ({busy, seed_err} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b want 00", {busy, seed_err}); end
        do_reset();
    endtask

    task automatic test_single();
        int nb, nd, fv, da, dr, w, mm;
        logic [NREQ-1:0] dv;
        req = 4'b0001;
        len[0 +: LEN_W] = 8'd31;
        tick();
        w = m_pick(4'b0001);
        checks++; if (grant !== 4'b0001 || busy !== 1'b1 || bit_valid !== 1'b0) begin
            errors++; $display("FAIL single_grant: grant=%b busy=%b valid=%b want 0001/1/0", grant, busy, bit_valid); end
        req = '0;
        watch_burst(50, 0, '0, nb, nd, fv, da, dr, dv);
        checks++; if (nb !== 31 || fv !== 2) begin errors++; $display("FAIL single_count: bits=%0d first=%0d want 31/2", nb, fv); end
        mm = 0;
        for (int i = 0; i < 31; i++) if (i >= obs_bits.size() || obs_bits[i] !== ((i == 30) ? 1'b1 : 1'b0) || m_next() !== obs_bits[i]) mm++;
        checks++; if (mm != 0) begin errors++; $display("FAIL single_bits: %0d bit errors, want 30 zeros then 1", mm); end
        checks++; if (nd !== 1 || da !== 32 || dv !== 4'b0001) begin
            errors++; $display("FAIL single_done: pulses=%0d at=%0d vec=%b want 1/32/0001", nd, da, dv); end
        checks++; if (dr !== 33) begin errors++; $display("FAIL single_drop: busy low at %0d want 33 (w=%0d)", dr, w); end
    endtask

    task automatic test_round_robin();
        int nb, nd, fv, da, dr, w, mm;
        logic [NREQ-1:0] dv;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) len[i*LEN_W +: LEN_W] = 8'd2;
        tick();
        for (int b = 0; b < 5; b++) begin
            w = m_pick(4'b1111);
            checks++; if (grant !== (4'b0001 << order[b]) || w != order[b]) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", b, grant, 4'b0001 << order[b]); end
            watch_burst(12, 0, '0, nb, nd, fv, da, dr, dv);
            mm = 0;
            for (int i = 0; i < 2; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next() || obs_ids[i] != w) mm++;
            checks++; if (nb !== 2 || mm != 0 || dv !== (4'b0001 << w)) begin
                errors++; $display("FAIL rr_burst[%0d]: bits=%0d errs=%0d done=%b", b, nb, mm, dv); end
            checks++; if (dr !== 4) begin errors++; $display("FAIL rr_spacing[%0d]: drop at %0d want 4", b, dr); end
            if (b == 4) req = '0;
            else tick();
        end
    endtask

    task automatic test_continuity();
        int nb, nd, fv, da, dr, w, mm, total;
        logic [NREQ-1:0] dv;
        do_reset();
        mm = 0; total = 0;
        for (int k = 1; k <= 2; k++) begin
            req = 4'b0001 << k;
            len[k*LEN_W +: LEN_W] = 8'd10;
            tick();
            w = m_pick(req);
            checks++; if (grant !== (4'b0001 << k)) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", k, grant, 4'b0001 << k); end
            req = '0;
            watch_burst(20, 0, '0, nb, nd, fv, da, dr, dv);
            total += nb;
            for (int i = 0; i < 10; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next() || obs_ids[i] != w) mm++;
        end
        checks++; if (total != 20 || mm != 0) begin errors++; $display("FAIL continuity: bits=%0d errs=%0d want 20/0", total, mm); end
    endtask

    task automatic test_seed();
        int nb, nd, fv, da, dr, w, mm;
        logic [NREQ-1:0] dv;
        seed_load = 1'b1; seed = 31'h7FFFFFFF; req = 4'b0001; len[0 +: LEN_W] = 8'd3;
        tick();
        seed_load = 1'b0;
        m_seed(31'h7FFFFFFF);
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL seed_suppress: grant=%b busy=%b want 0000/0", grant, busy); end
        tick();
        w = m_pick(4'b0001);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL seed_grant: got %b want 0001", grant); end
        req = '0;
        watch_burst(10, 0, '0, nb, nd, fv, da, dr, dv);
        mm = 0;
        for (int i = 0; i < 3; i++) if (i >= obs_bits.size() || obs_bits[i] !== 1'b1 || m_next() !== 1'b1) mm++;
        checks++; if (nb !== 3 || mm != 0) begin errors++; $display("FAIL seed_ones: bits=%0d errs=%0d want 3 ones", nb, mm); end
        seed_load = 1'b1; seed = 31'd0;
        tick();
        seed_load = 1'b0;
        m_seed(31'd0);
        req = 4'b0001; len[0 +: LEN_W] = 8'd31;
        tick();
        w = m_pick(4'b0001);
        req = '0;
        watch_burst(40, 0, '0, nb, nd, fv, da, dr, dv);
        mm = 0;
        for (int i = 0; i < 31; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next()) mm++;
        checks++; if (nb !== 31 || mm != 0 || obs_bits[30] !== 1'b1) begin errors++; $display("FAIL seed_zero: bits=%0d errs=%0d", nb, mm); end
        checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL seed_err_idle: got %b want 0", seed_err); end
        req = 4'b0100; len[2*LEN_W +: LEN_W] = 8'd12;
        tick();
        w = m_pick(4'b0100);
        req = '0;
        watch_burst(20, 5, 31'($urandom) | 31'd1, nb, nd, fv, da, dr, dv);
        mm = 0;
        for (int i = 0; i < 12; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next()) mm++;
        checks++; if (nb !== 12 || mm != 0) begin errors++; $display("FAIL seed_run_stream: bits=%0d errs=%0d want 12/0", nb, mm); end
        checks++; if (seed_err !== 1'b1) begin errors++; $display("FAIL seed_err_run: got %b want 1", seed_err); end
    endtask

    task automatic test_len0();
        int nb, nd, fv, da, dr, w, mm;
        logic [NREQ-1:0] dv;
        req = 4'b0100; len[2*LEN_W +: LEN_W] = 8'd0;
        tick();
        w = m_pick(4'b0100);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL len0_grant: got %b want 0100", grant); end
        req = '0;
        watch_burst(300, 0, '0, nb, nd, fv, da, dr, dv);
        mm = 0;
        for (int i = 0; i < 256; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next() || obs_ids[i] != w) mm++;
        checks++; if (nb !== 256 || mm != 0) begin errors++; $display("FAIL len0_bits: bits=%0d errs=%0d want 256/0", nb, mm); end
        checks++; if (nd !== 1 || dv !== 4'b0100 || da !== 257 || dr !== 258) begin
            errors++; $display("FAIL len0_done: pulses=%0d vec=%b at=%0d drop=%0d want 1/0100/257/258", nd, dv, da, dr); end
    endtask

    task automatic test_random();
        int nb, nd, fv, da, dr, w, mm, L;
        logic [NREQ-1:0] dv, r;
        int lens[NREQ];
        for (int b = 0; b < 12; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            r = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                lens[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
                len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
            end
            req = r;
            tick();
            w = m_pick(r);
            L = (lens[w] == 0) ? 256 : lens[w];
            req = NREQ'($urandom);
            len = (NREQ*LEN_W)'($urandom);
            checks++; if (grant !== (4'b0001 << w)) begin errors++; $display("FAIL rand_grant[%0d]: got %b want %b", b, grant, 4'b0001 << w); end
            watch_burst(L + 10, 0, '0, nb, nd, fv, da, dr, dv);
            req = '0;
            mm = 0;
            for (int i = 0; i < L; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next() || obs_ids[i] != w) mm++;
            checks++; if (nb !== L || mm != 0 || fv !== 2) begin
                errors++; $display("FAIL rand_bits[%0d]: bits=%0d want %0d errs=%0d first=%0d", b, nb, L, mm, fv); end
            checks++; if (nd !== 1 || dv !== (4'b0001 << w) || da !== L + 1 || dr !== L + 2) begin
                errors++; $display("FAIL rand_timing[%0d]: pulses=%0d vec=%b done=%0d drop=%0d L=%0d", b, nd, dv, da, dr, L); end
        end
    endtask

    task automatic test_reset_mid();
        int nb, nd, fv, da, dr, w, mm, seen, dseen;
        logic [NREQ-1:0] dv;
        req = 4'b0010; len[1*LEN_W +: LEN_W] = 8'd20;
        tick();
        w = m_pick(4'b0010);
        req = '0;
        seen = 0;
        for (int c = 0; c < 30 && seen < 5; c++) begin
            tick();
            if (bit_valid) seen++;
        end
        checks++; if (seen != 5) begin errors++; $display("FAIL mid_reach: saw %0d bits want 5", seen); end
        rst_n = 1'b0;
        #1;
        checks++; if ({grant, bit_valid, busy, done, bit_out, bit_id} !== '0) begin
            errors++; $display("FAIL mid_clear: grant=%b valid=%b busy=%b done=%b", grant, bit_valid, busy, done); end
        dseen = 0;
        repeat (3) begin tick(); if (done != '0 || bit_valid) dseen++; end
        checks++; if (dseen != 0) begin errors++; $display("FAIL mid_nodone: %0d active cycles want 0", dseen); end
        @(negedge clk);
        rst_n = 1'b1;
        m_seed(31'd1);
        m_rr = 0;
        req = 4'b1010;
        len[1*LEN_W +: LEN_W] = 8'd31; len[3*LEN_W +: LEN_W] = 8'd31;
        tick();
        w = m_pick(4'b1010);
        checks++; if (grant !== (4'b0001 << w)) begin errors++; $display("FAIL mid_rr: got %b want %b", grant, 4'b0001 << w); end
        req = '0;
        watch_burst(40, 0, '0, nb, nd, fv, da, dr, dv);
        mm = 0;
        for (int i = 0; i < 31; i++) if (i >= obs_bits.size() || obs_bits[i] !== m_next()) mm++;
        checks++; if (nb !== 31 || mm != 0) begin errors++; $display("FAIL mid_restart: bits=%0d errs=%0d want 31/0", nb, mm); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_seed(31'd1);
        m_rr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_continuity();
        test_seed();
        test_len0();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
